// File: rtl/axis_packetizer.sv
// axis_packetizer: groups a tlast-less AXI-Stream into fixed PKT_LEN-beat
// packets and marks the final beat of each with m_axis_tlast. A registered
// output slice gives one cycle of latency at full throughput.
// Optional feature macro: AXIS_PKT_TIMEOUT_EN -- when defined, a partial
// packet that sees TIMEOUT idle input cycles is completed with PAD_WORD beats.
module axis_packetizer #(
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter int                        PKT_LEN        = 16,
    parameter int                        TIMEOUT        = 64,
    parameter logic [AXI_DATA_WIDTH-1:0] PAD_WORD       = '0
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic [15:0]               pkt_count,
    output logic                      busy
);

    localparam int CNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PAD
    } state_t;

    state_t                      state;
    state_t                      next_state;
    logic [CNT_W-1:0]            beat_cnt;
    logic                        slot_free;
    logic                        in_fire;
    logic                        pad_fire;
    logic                        load;
    logic                        last_beat;
    logic [AXI_DATA_WIDTH-1:0]   load_data;
    logic                        tmo;

    assign slot_free     = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = slot_free && (state != PAD) && aresetn;
    assign in_fire       = s_axis_tvalid && s_axis_tready;
    assign load          = in_fire || pad_fire;
    assign last_beat     = (beat_cnt == LAST_IDX);
    assign busy          = (state != IDLE);

`ifdef AXIS_PKT_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] idle_tmr;

    assign pad_fire  = (state == PAD) && slot_free;
    assign load_data = in_fire ? s_axis_tdata : PAD_WORD;
    assign tmo       = (state == FILL) && !s_axis_tvalid && (idle_tmr == TMR_LAST);

    // Idle timer: counts input-idle cycles mid-packet; any valid input clears it.
    // It also clears on the expiry cycle itself so it never overflows.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            idle_tmr <= '0;
        end else if ((state == FILL) && !s_axis_tvalid && (idle_tmr != TMR_LAST)) begin
            idle_tmr <= idle_tmr + 1'b1;
        end else begin
            idle_tmr <= '0;
        end
    end
`else
    logic unused_cfg;

    assign pad_fire   = 1'b0;
    assign load_data  = s_axis_tdata;
    assign tmo        = 1'b0;
    assign unused_cfg = ^{PAD_WORD, TIMEOUT};
`endif

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: packet start, completion and timeout-driven padding.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_fire && (PKT_LEN > 1)) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                if (load && last_beat) begin
                    next_state = IDLE;
                end else if (tmo) begin
                    next_state = PAD;
                end
            end
            PAD: begin
                if (pad_fire && last_beat) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Beat position within the current packet; wraps after the tlast beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt <= '0;
        end else if (load) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        end
    end

    // Output slice: load a new beat when the slot is free, else hold until accepted.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (load) begin
            m_axis_tdata  <= load_data;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= last_beat;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end
    end

    // Completed-packet counter, advanced on each master-side tlast handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_count <= '0;
        end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            pkt_count <= pkt_count + 16'd1;
        end
    end

endmodule

// File: doc/axis_packetizer.md
# axis_packetizer

AXI-Stream framing stage that sits directly downstream of `axis_fifo` and consumes its tlast-less master stream. It groups consecutive beats into fixed-length packets of `PKT_LEN` beats and drives `m_axis_tlast` on the final beat of each packet. A registered output slice provides full throughput and one-cycle latency. An optional idle-timeout flush pads a stalled partial packet with `PAD_WORD` beats so downstream consumers always receive complete packets.

## Interface
- `AXI_DATA_WIDTH`, 32, tdata width in bits
- `PKT_LEN`, 16, beats per packet, ≥1
- `TIMEOUT`, 64, idle cycles mid-packet before pad flush starts, ≥1 (used only with the macro)
- `PAD_WORD`, 0, tdata value of inserted pad beats (used only with the macro)

Ports:
- `aclk`  in  1  clock; all logic is on the rising edge
- `aresetn`  in  1  asynchronous active-low reset
- `s_axis_tdata`  in  AXI_DATA_WIDTH  input beat data, normally driven by the FIFO master port
- `s_axis_tvalid`  in  1  input beat valid
- `s_axis_tready`  out  1  input ready
- `m_axis_tdata`  out  AXI_DATA_WIDTH  output beat data
- `m_axis_tvalid`  out  1  output beat valid
- `m_axis_tready`  in  1  output ready
- `m_axis_tlast`  out  1  last beat of packet
- `pkt_count`  out  16  packets completed on the master side, wraps modulo 2^16
- `busy`  out  1  high when a packet is partially sent (state ≠ IDLE)

## Operation
- Output register: `m_axis_tdata`, `m_axis_tvalid` and `m_axis_tlast` are flops.
  - slot_free = !m_axis_tvalid || m_axis_tready.
  - `s_axis_tready` = slot_free && state≠PAD && aresetn.
- Beat counter `beat_cnt`:
  - Width max(1, $clog2(PKT_LEN)).
  - Increments on every beat loaded into the output register, input or pad.
  - A beat loaded while beat_cnt==PKT_LEN-1 gets tlast=1, and beat_cnt wraps to 0.
- States:
  - IDLE: beat_cnt==0.
  - FILL: 0<beat_cnt.
  - PAD: pad insertion, macro builds only.
- Transitions:
  - IDLE→FILL on an accepted beat when PKT_LEN>1.
  - FILL→IDLE when the tlast beat is loaded.
  - FILL→PAD on timeout.
  - PAD→IDLE when the pad beat carrying tlast is loaded.
- PKT_LEN==1: every beat has tlast=1 and the block stays in IDLE.
- `pkt_count` increments on each master handshake with tlast=1.
- Data is passed unmodified, in order; no beats are dropped or duplicated.
- Reset mid-packet:
  - Partial packet is discarded.
  - Output register and all counters are cleared.
  - The next accepted beat starts a new packet at beat_cnt=0.

## Timing
- Reset values:
  - `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0.
  - `pkt_count`=0, `busy`=0, state IDLE, beat_cnt=0, idle timer=0.
  - `s_axis_tready`=0 while aresetn is low; it is 1 in the first cycle after release.
- Latency: a beat accepted at edge N is presented on the master side after edge N (visible in cycle N+1).
- Throughput: 1 beat/cycle with `m_axis_tready` held high.
- Handshake rules:
  - Once asserted, `m_axis_tvalid` stays high and tdata/tlast stay stable until `m_axis_tready`.
  - `s_axis_tready` never depends on `s_axis_tvalid`.
- Idle timer (macro only):
  - Counts only in FILL, on cycles where `s_axis_tvalid`==0.
  - Clears on any cycle where `s_axis_tvalid`==1; backpressure does not count as idle.
  - When the timer is TIMEOUT-1 and `s_axis_tvalid`==0, the next state is PAD.
  - If `s_axis_tvalid` rises in that same cycle, the beat wins and the block stays in FILL.
- PAD:
  - One PAD_WORD beat is loaded per cycle in which slot_free is true.
  - The packet is completed to exactly PKT_LEN beats, the last carrying tlast=1.
  - The block is back in IDLE the cycle after; `s_axis_tready` is deasserted throughout PAD.

## Configuration
- `AXIS_PKT_TIMEOUT_EN` defined:
  - Idle timer, PAD state and pad insertion are compiled in.
- Not defined:
  - No timer and no PAD state; `TIMEOUT` and `PAD_WORD` are ignored.
  - A partial packet waits indefinitely for input.

## Test plan
- PKT_LEN=4, 8 continuous beats 0x1..0x8, tready=1 → outputs 0x1..0x8 one cycle delayed, tlast on 0x4 and 0x8, pkt_count=2, no bubbles.
- Random `m_axis_tready` toggling, 100 beats, PKT_LEN=16 → data order preserved, tvalid/tdata held during stalls, tlast every 16th beat, pkt_count=6.
- PKT_LEN=1, 3 beats → tlast=1 on every beat, busy stays 0, pkt_count=3.
- Macro on, PKT_LEN=4, TIMEOUT=8, PAD_WORD=0xDEAD; send 0xA,0xB then idle → after 8 idle cycles outputs 0xDEAD,0xDEAD with tlast on the second; s_tready=0 during PAD; pkt_count=1.
- Macro on, idle for 7 cycles then a beat arrives on the 8th → no padding, the packet continues normally; also assert `m_axis_tready`=0 for 20 cycles mid-packet with s_tvalid high → no timeout.
- aresetn pulsed low after 2 of 4 beats → outputs clear immediately; the next 4 beats form a full packet with tlast on the 4th; pkt_count restarts at 0.
